// File: rtl/jt49_pkg.sv
// Shared constants for the JT49 volume/mixer path: frame phase encoding and
// the 32-entry logarithmic volume table (1.5 dB per step, 0 = silence).
package jt49_pkg;

  typedef enum logic [1:0] {
    PH_A   = 2'd0,
    PH_B   = 2'd1,
    PH_C   = 2'd2,
    PH_SUM = 2'd3
  } phase_t;

  localparam logic [7:0] VOL_TABLE [32] = '{
    8'd0,   8'd1,   8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd4,
    8'd5,   8'd6,   8'd7,   8'd8,   8'd10,  8'd11,  8'd14,  8'd16,
    8'd19,  8'd23,  8'd27,  8'd32,  8'd38,  8'd45,  8'd54,  8'd64,
    8'd76,  8'd90,  8'd108, 8'd128, 8'd152, 8'd181, 8'd215, 8'd255
  };

  // Table index for one channel: silent when gated off, envelope when M=1,
  // otherwise the fixed level L mapped onto the odd table entries.
  function automatic logic [4:0] vol_index(input logic gate, input logic [4:0] amp,
                                           input logic [4:0] env);
    logic [4:0] idx;
    idx = '0;
    if (gate) begin
      if (amp[4])               idx = env;
      else if (amp[3:0] != '0)  idx = {amp[3:0], 1'b1};
    end
    return idx;
  endfunction

endpackage

// File: rtl/jt49_vol_lut.sv
// Registered volume ROM: one-cycle latency, advances only on cen.
module jt49_vol_lut
  import jt49_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic [4:0] idx,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (cen) q <= VOL_TABLE[idx];
  end

endmodule

// File: rtl/jt49_vol_mix.sv
// Three-channel tone/noise gating and volume mixing, time-multiplexed over a
// four-phase frame sharing one volume ROM.
module jt49_vol_mix
  import jt49_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic [4:0] env,
  input  logic [4:0] amp_a,
  input  logic [4:0] amp_b,
  input  logic [4:0] amp_c,
  input  logic       tone_a,
  input  logic       tone_b,
  input  logic       tone_c,
  input  logic       noise,
  input  logic [5:0] mix,
  output logic [7:0] ch_a,
  output logic [7:0] ch_b,
  output logic [7:0] ch_c,
  output logic [9:0] sound,
  output logic       sample
);

  phase_t     phase;
  logic [2:0] gate;
  logic [4:0] idx;
  logic [7:0] lut_q;
  logic [9:0] acc;

  assign gate[0] = (tone_a | mix[0]) & (noise | mix[3]);
  assign gate[1] = (tone_b | mix[1]) & (noise | mix[4]);
  assign gate[2] = (tone_c | mix[2]) & (noise | mix[5]);

  // Only the channel owning the current phase reaches the ROM, so inputs of
  // the other channels are ignored until their own phase comes round.
  always_comb begin
    idx = '0;
    case (phase)
      PH_A:   idx = vol_index(gate[0], amp_a, env);
      PH_B:   idx = vol_index(gate[1], amp_b, env);
      PH_C:   idx = vol_index(gate[2], amp_c, env);
      PH_SUM: idx = '0;
    endcase
  end

  jt49_vol_lut u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .idx   (idx),
    .q     (lut_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= PH_A;
      acc    <= '0;
      ch_a   <= '0;
      ch_b   <= '0;
      ch_c   <= '0;
      sound  <= '0;
      sample <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (cen) begin
        phase <= phase_t'(phase + 2'd1);
        case (phase)
          PH_A: ;
          PH_B: begin
            ch_a <= lut_q;
            acc  <= {2'b00, lut_q};
          end
          PH_C: begin
            ch_b <= lut_q;
            acc  <= acc + {2'b00, lut_q};
          end
          PH_SUM: begin
            ch_c   <= lut_q;
            sound  <= acc + {2'b00, lut_q};
            sample <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt49_vol_mix.sv
// Randomised and directed bench for jt49_vol_mix against a frame-level model.
module tb_jt49_vol_mix;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic [4:0] env, amp_a, amp_b, amp_c;
  logic       tone_a, tone_b, tone_c, noise;
  logic [5:0] mix;
  logic [7:0] ch_a, ch_b, ch_c;
  logic [9:0] sound;
  logic       sample;

  jt49_vol_mix dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .env    (env),
    .amp_a  (amp_a),
    .amp_b  (amp_b),
    .amp_c  (amp_c),
    .tone_a (tone_a),
    .tone_b (tone_b),
    .tone_c (tone_c),
    .noise  (noise),
    .mix    (mix),
    .ch_a   (ch_a),
    .ch_b   (ch_b),
    .ch_c   (ch_c),
    .sound  (sound),
    .sample (sample)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Volume curve straight from the dB formula.
  int tbl [32];

  function automatic int level(input logic tone, input logic tdis, input logic ndis,
                               input logic [4:0] amp);
    if (!((tone || tdis) && (noise || ndis))) return 0;
    if (amp[4]) return tbl[env];
    if (amp[3:0] == 0) return 0;
    return tbl[int'(amp[3:0]) * 2 + 1];
  endfunction

  // Frame-level model: cen edge n of a frame captures channel n's level; each
  // channel output shows it one cen later, the sum after the fourth.
  int mcnt = 0;
  int lvl [3];
  int exp_ch [3];
  int exp_sound = 0;
  int exp_sample = 0;
  bit checking = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mcnt = 0;
      lvl = '{0, 0, 0};
      exp_ch = '{0, 0, 0};
      exp_sound = 0;
      exp_sample = 0;
    end else begin
      exp_sample = 0;
      if (cen) begin
        case (mcnt)
          0: lvl[0] = level(tone_a, mix[0], mix[3], amp_a);
          1: begin exp_ch[0] = lvl[0]; lvl[1] = level(tone_b, mix[1], mix[4], amp_b); end
          2: begin exp_ch[1] = lvl[1]; lvl[2] = level(tone_c, mix[2], mix[5], amp_c); end
          default: begin
            exp_ch[2] = lvl[2];
            exp_sound = lvl[0] + lvl[1] + lvl[2];
            exp_sample = 1;
          end
        endcase
        mcnt = (mcnt + 1) % 4;
      end
    end
    #1;
    if (checking) begin
      check("ch_a", int'(ch_a), exp_ch[0]);
      check("ch_b", int'(ch_b), exp_ch[1]);
      check("ch_c", int'(ch_c), exp_ch[2]);
      check("sound", int'(sound), exp_sound);
      check("sample", int'(sample), exp_sample);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_random(input bit rand_cen);
    env    = 5'($urandom);
    amp_a  = 5'($urandom);
    amp_b  = 5'($urandom);
    amp_c  = 5'($urandom);
    tone_a = 1'($urandom);
    tone_b = 1'($urandom);
    tone_c = 1'($urandom);
    noise  = 1'($urandom);
    mix    = 6'($urandom);
    if (rand_cen) cen = 1'($urandom);
  endtask

  task automatic set_all(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                         input logic [5:0] m);
    amp_a = a; amp_b = b; amp_c = c; mix = m;
  endtask

  initial begin
    tbl[0] = 0;
    for (int i = 1; i < 32; i++)
      tbl[i] = $rtoi(255.0 * (10.0 ** (-1.5 * real'(31 - i) / 20.0)) + 0.5);

    rst_n = 1'b0; cen = 1'b0; env = '0; noise = 1'b0; mix = '0;
    amp_a = '0; amp_b = '0; amp_c = '0; tone_a = 1'b0; tone_b = 1'b0; tone_c = 1'b0;
    #1;
    check("rst_sound", int'(sound), 0);
    check("rst_sample", int'(sample), 0);
    checking = 1'b1;
    run(3);
    @(negedge clk) rst_n = 1'b1;

    // Full-scale fixed level on all channels.
    cen = 1'b1;
    set_all(5'h0F, 5'h0F, 5'h0F, 6'h3F);
    run(12);
    check("full_sound", int'(sound), 765);
    check("full_ch_c", int'(ch_c), 255);

    // Envelope mode on A only.
    set_all(5'h10, 5'h00, 5'h00, 6'h3F);
    env = 5'd30;
    run(8);
    check("env30_ch_a", int'(ch_a), 215);
    check("env30_sound", int'(sound), 215);
    env = 5'd0;
    run(8);
    check("env0_sound", int'(sound), 0);

    // Mixer gating: noise low blocks A unless noise disabled.
    set_all(5'h0F, 5'h00, 5'h00, 6'h00);
    noise = 1'b0; tone_a = 1'b1;
    run(8);
    check("gate_off_ch_a", int'(ch_a), 0);
    mix = 6'h38;
    run(8);
    check("gate_on_ch_a", int'(ch_a), 255);

    // cen every third clock with changing inputs.
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      cen = (i % 3 == 0);
      if (i % 5 == 0) drive_random(1'b0);
    end

    // Reset pulse while the frame is in phase 2.
    cen = 1'b1;
    set_all(5'h0F, 5'h0F, 5'h0F, 6'h3F);
    begin
      int guard = 0;
      while (mcnt != 2 && guard < 20) begin @(negedge clk); guard++; end
      check("phase2_reached", mcnt, 2);
    end
    run(1);
    rst_n = 1'b0;
    #1;
    check("rst_imm_ch_a", int'(ch_a), 0);
    check("rst_imm_sound", int'(sound), 0);
    check("rst_imm_sample", int'(sample), 0);
    @(negedge clk) rst_n = 1'b1;
    run(6);

    // Fixed-level sweep on A.
    for (int l = 0; l < 16; l++) begin
      set_all(5'(l), 5'h00, 5'h00, 6'h3F);
      run(8);
      check($sformatf("sweep_L%0d", l), int'(ch_a), (l == 0) ? 0 : tbl[2 * l + 1]);
    end

    // Random traffic with random cen.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      drive_random(1'b1);
    end

    run(2);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/jt49_vol_mix.md
JT49_VOL_MIX -- requirements
Module: jt49_vol_mix

Interface
REQ-001 SHALL have parameter: none; table contents fixed in shared package.
REQ-002 SHALL have port clk  in  1  system clock.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cen  in  1  clock enable, same divided enable as envelope generator.
REQ-005 SHALL have port env  in  5  envelope generator level, 0 = silent, 31 = max.
REQ-006 SHALL have ports amp_a, amp_b, amp_c  in  5 each  amplitude regs: bit4 = M (use env), bits3:0 = fixed level L.
REQ-007 SHALL have ports tone_a, tone_b, tone_c  in  1 each  square-wave tone outputs.
REQ-008 SHALL have port noise  in  1  noise generator output.
REQ-009 SHALL have port mix  in  6  mixer reg: bits2:0 tone disable A/B/C, bits5:3 noise disable A/B/C (1 = disabled).
REQ-010 SHALL have ports ch_a, ch_b, ch_c  out  8 each  per-channel linear level.
REQ-011 SHALL have port sound  out  10  sum of three channel levels.
REQ-012 SHALL have port sample  out  1  one-clk strobe: new sound value valid.

Function
REQ-013 SHALL run a 2-bit phase counter 0->1->2->3->0, advancing only on clk edges with cen=1.
REQ-014 SHALL compute gate_x = (tone_x | mix[x]) & (noise | mix[x+3]).
REQ-015 SHALL form index idx_x = 0 if gate_x=0; else env if M=1; else 0 if L=0; else {L,1'b1}.
REQ-016 SHALL sample a channel's inputs only in its own phase: A in phase 0, B in 1, C in 2; changes elsewhere ignored for that frame.
REQ-017 SHALL map index via 32x8 table: T[0]=0, T[i]=round(255*10^(-1.5*(31-i)/20)) for i>=1; T[31]=255, T[30]=215, T[29]=181, T[1]=1.
REQ-018 SHALL, phase 0: lut_q<=T[idx_a].
REQ-019 SHALL, phase 1: ch_a<=lut_q, acc<=lut_q, lut_q<=T[idx_b].
REQ-020 SHALL, phase 2: ch_b<=lut_q, acc<=acc+lut_q, lut_q<=T[idx_c].
REQ-021 SHALL, phase 3: ch_c<=lut_q, sound<=acc+lut_q, sample<=1.
REQ-022 SHALL drive sample high exactly one clk cycle; cleared on next clk regardless of cen.
REQ-023 SHALL use 10-bit acc; max sum 765, no overflow, no saturation logic.
REQ-024 SHALL hold all state and outputs when cen=0.
REQ-025 SHALL give latency: channel A inputs sampled at phase 0 appear in sound at phase-3 edge (3 cen later); one sample per 4 cen.
REQ-026 SHALL keep ch_x/sound stable between updates (registered, glitch-free).

Reset
REQ-027 SHALL, on rst_n low: phase=0, lut_q=0, acc=0, ch_a/b/c=0, sound=0, sample=0.
REQ-028 SHALL abort partial frame on mid-frame reset; first sample after release at 4th cen edge.
REQ-029 SHALL not require clk running during reset assertion.

Structure
REQ-030 SHALL place 32x8 volume table constant and phase encodings in shared package jt49_pkg.
REQ-031 SHALL implement table lookup in sub-module jt49_vol_lut (registered ROM, cen-qualified, 1-cycle latency).
REQ-032 SHALL keep gating, index, sequencing, accumulation in jt49_vol_mix.

Verification
REQ-033 Reset then cen every clk, amp_a=amp_b=amp_c=5'h0F, mix=6'h3F -> sound=765, ch_x=255, sample every 4 clk.
REQ-034 amp_a=5'h10, env=30, others 0, mix=6'h3F -> ch_a=215, sound=215; env=0 -> sound=0 next frame.
REQ-035 mix=6'h00, noise=0, amp_a=5'h0F, tone_a=1 -> ch_a=0; mix=6'h38 -> ch_a=255.
REQ-036 cen every 3rd clk -> sample period 12 clk, 1 clk wide; outputs frozen between cen.
REQ-037 rst_n pulsed during phase 2 -> all outputs 0 immediately, next sample after 4 cen.
REQ-038 Sweep L 0..15 fixed mode -> ch_a = T[{L,1}] (L=0 -> 0); compare against package table.
